// File: rtl/proc_datapath.sv
// Multi-cycle datapath: register bank, ALU and iterative shifter behind a valid/ready command port.
// One micro-op at a time: accept -> EXEC (read + ALU) -> SHIFT x k -> WB (write, flags, out_valid).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | op_ready high, waiting for a command
//   EXEC  | read operands, ALU result into work register
//   SHIFT | one shift step per cycle, steps_left counts down to 1
//   WB    | bank write, out_data/flags update, out_valid pulse
module proc_datapath #(
    parameter int N  = 8,
    parameter int A  = 3,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [A-1:0]  sel_a,
    input  logic [A-1:0]  sel_b,
    input  logic [A-1:0]  sel_d,
    input  logic [3:0]    alu_sel,
    input  logic [2:0]    shift_sel,
    input  logic [SW-1:0] shift_amt,
    input  logic          ld_in,
    input  logic [N-1:0]  in_data,
    input  logic          il,
    input  logic          ir,
    input  logic          wr_en,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic          z,
    output logic          s,
    output logic          v,
    output logic          c,
    input  logic [A-1:0]  dbg_sel,
    output logic [N-1:0]  dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_WB} state_t;

    state_t state, state_nxt;

    logic [2**A-1:0][N-1:0] regs;

    logic [A-1:0]  c_sel_a, c_sel_b, c_sel_d;
    logic [3:0]    c_alu;
    logic [2:0]    c_shf;
    logic [SW-1:0] c_amt;
    logic          c_ld, c_wr;
    logic [N-1:0]  c_in;

    logic [N-1:0]  work;
    logic          work_c, work_v;
    logic [SW-1:0] steps_left;

    logic [N-1:0]  a_op, b_op, addend, logic_res, alu_res;
    logic [N:0]    sum;
    logic          arith, cin, alu_c, alu_v;
    logic [N-1:0]  shifted;
    logic          shift_c;
    logic          shift_go;
    logic          accept;

    assign op_ready = (state == S_IDLE);
    assign accept   = op_valid && op_ready;
    assign dbg_data = regs[dbg_sel];

    always_comb begin
        shift_go = 1'b0;
        case (c_shf)
            3'b001, 3'b010, 3'b100, 3'b101, 3'b110: shift_go = (c_amt != '0);
            default:                                shift_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (op_valid) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = shift_go ? S_SHIFT : S_WB;
            S_SHIFT: if (steps_left == SW'(1)) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU: arithmetic codes are a + addend + cin on N+1 bits
    always_comb begin
        a_op      = c_ld ? c_in : regs[c_sel_a];
        b_op      = regs[c_sel_b];
        arith     = 1'b0;
        cin       = 1'b0;
        addend    = '0;
        logic_res = a_op;
        case (c_alu)
            4'b0001: begin arith = 1'b1; addend = N'(1); end
            4'b0010: begin arith = 1'b1; addend = b_op; end
            4'b0011: begin arith = 1'b1; addend = b_op; cin = 1'b1; end
            4'b0100: begin arith = 1'b1; addend = ~b_op; end
            4'b0101: begin arith = 1'b1; addend = ~b_op; cin = 1'b1; end
            4'b0110: begin arith = 1'b1; addend = '1; end
            4'b1000: logic_res = a_op & b_op;
            4'b1010: logic_res = a_op | b_op;
            4'b1100: logic_res = a_op ^ b_op;
            4'b1110: logic_res = ~a_op;
            default: logic_res = a_op;
        endcase
        sum     = {1'b0, a_op} + {1'b0, addend} + (N+1)'(cin);
        alu_res = arith ? sum[N-1:0] : logic_res;
        alu_c   = arith & sum[N];
        alu_v   = arith & (a_op[N-1] == addend[N-1]) & (sum[N-1] != a_op[N-1]);
    end

    always_comb begin
        shifted = work;
        shift_c = work_c;
        case (c_shf)
            3'b001: begin shifted = {work[N-2:0], ir};          shift_c = work[N-1]; end
            3'b010: begin shifted = {il, work[N-1:1]};          shift_c = work[0];   end
            3'b100: begin shifted = {work[N-1], work[N-1:1]};   shift_c = work[0];   end
            3'b101: begin shifted = {work[N-2:0], work[N-1]};   shift_c = work[N-1]; end
            3'b110: begin shifted = {work[0], work[N-1:1]};     shift_c = work[0];   end
            default: begin shifted = work;                      shift_c = work_c;    end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs       <= '0;
            c_sel_a    <= '0;
            c_sel_b    <= '0;
            c_sel_d    <= '0;
            c_alu      <= '0;
            c_shf      <= '0;
            c_amt      <= '0;
            c_ld       <= 1'b0;
            c_wr       <= 1'b0;
            c_in       <= '0;
            work       <= '0;
            work_c     <= 1'b0;
            work_v     <= 1'b0;
            steps_left <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            z          <= 1'b0;
            s          <= 1'b0;
            v          <= 1'b0;
            c          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        c_sel_a <= sel_a;
                        c_sel_b <= sel_b;
                        c_sel_d <= sel_d;
                        c_alu   <= alu_sel;
                        c_shf   <= shift_sel;
                        c_amt   <= shift_amt;
                        c_ld    <= ld_in;
                        c_wr    <= wr_en;
                        c_in    <= in_data;
                    end
                end
                S_EXEC: begin
                    work       <= (c_shf == 3'b011) ? '0 : alu_res;
                    work_c     <= alu_c;
                    work_v     <= alu_v;
                    steps_left <= c_amt;
                end
                S_SHIFT: begin
                    work       <= shifted;
                    work_c     <= shift_c;
                    work_v     <= 1'b0;
                    steps_left <= steps_left - SW'(1);
                end
                S_WB: begin
                    if (c_wr) regs[c_sel_d] <= work;
                    out_data  <= work;
                    z         <= (work == '0);
                    s         <= work[N-1];
                    v         <= work_v;
                    c         <= work_c;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_datapath.sv
// Bench for proc_datapath: directed scenarios plus randomized commands against an arithmetic model.
module tb_proc_datapath;

    localparam int N = 8;
    localparam int A = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] sel_a = '0, sel_b = '0, sel_d = '0;
    logic [3:0] alu_sel = '0;
    logic [2:0] shift_sel = '0;
    logic [2:0] shift_amt = '0;
    logic       ld_in = 1'b0;
    logic [7:0] in_data = '0;
    logic       il = 1'b0, ir = 1'b0;
    logic       wr_en = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       z, s, v, c;
    logic [2:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    int n_pass = 0;
    int n_total = 0;
    int model_regs [8];

    always #5 clk = ~clk;

    proc_datapath #(.N(N), .A(A)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d), .alu_sel(alu_sel),
        .shift_sel(shift_sel), .shift_amt(shift_amt), .ld_in(ld_in), .in_data(in_data),
        .il(il), .ir(ir), .wr_en(wr_en), .out_valid(out_valid), .out_data(out_data),
        .z(z), .s(s), .v(v), .c(c), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic int steps_of(input int shf, input int amt);
        if (shf == 1 || shf == 2 || shf == 4 || shf == 5 || shf == 6) return amt;
        return 0;
    endfunction

    // Reference: flags packed as z*8 + s*4 + v*2 + c
    function automatic void model(input int a, input int b, input int alu, input int shf,
                                  input int amt, input int il_i, input int ir_i,
                                  output int res, output int fl);
        int add, cin, sum, ss, cf, vf, msb, k;
        bit ar;
        ar = 1; add = 0; cin = 0;
        res = a; cf = 0; vf = 0;
        case (alu)
            1: add = 1;
            2: add = b;
            3: begin add = b; cin = 1; end
            4: add = 255 - b;
            5: begin add = 255 - b; cin = 1; end
            6: add = 255;
            default: ar = 0;
        endcase
        if (ar) begin
            sum = a + add + cin;
            res = sum % 256;
            cf  = (sum >= 256) ? 1 : 0;
            ss  = to_signed8(a) + to_signed8(add) + cin;
            vf  = (ss > 127 || ss < -128) ? 1 : 0;
        end else begin
            case (alu)
                8:  res = a & b;
                10: res = a | b;
                12: res = a ^ b;
                14: res = 255 - a;
                default: res = a;
            endcase
        end
        if (shf == 3) res = 0;
        k = steps_of(shf, amt);
        for (int i = 0; i < k; i++) begin
            msb = res / 128;
            case (shf)
                1: begin cf = msb;     res = (res * 2) % 256 + ir_i; end
                2: begin cf = res % 2; res = res / 2 + il_i * 128; end
                4: begin cf = res % 2; res = res / 2 + msb * 128; end
                5: begin cf = msb;     res = (res * 2) % 256 + msb; end
                6: begin cf = res % 2; res = res / 2 + (res % 2) * 128; end
                default: ;
            endcase
            vf = 0;
        end
        fl = ((res == 0) ? 8 : 0) + ((res >= 128) ? 4 : 0) + vf * 2 + cf;
    endfunction

    // Drives one command, waits for out_valid; lat = negedges from accept to out_valid (-1 on timeout)
    task automatic do_cmd(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] sd,
                          input logic [3:0] alu, input logic [2:0] shf, input logic [2:0] amt,
                          input logic ld, input logic [7:0] din, input logic wr,
                          output logic [7:0] od, output logic [3:0] fl,
                          output int lat, output int rdy_low);
        int t;
        @(negedge clk);
        sel_a = sa; sel_b = sb; sel_d = sd; alu_sel = alu; shift_sel = shf;
        shift_amt = amt; ld_in = ld; in_data = din; wr_en = wr; op_valid = 1'b1;
        t = 0;
        while (!op_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = -1;
        rdy_low = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!op_ready) rdy_low++;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        od = out_data;
        fl = {z, s, v, c};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (op_ready !== 1'b1) $display("FAIL reset_op_ready got=%b exp=1", op_ready); else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++;
        if ({z, s, v, c} !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", {z, s, v, c}); else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            n_total++;
            if (dbg_data !== 8'h00) $display("FAIL reset_reg%0d got=%h exp=00", i, dbg_data); else n_pass++;
            model_regs[i] = 0;
        end
    endtask

    task automatic test_load_add;
        logic [7:0] od;
        logic [3:0] fl;
        int lat, rl;
        do_cmd(3'd0, 3'd0, 3'd1, 4'b0000, 3'b000, 3'd0, 1'b1, 8'h7F, 1'b1, od, fl, lat, rl);
        n_total++;
        if (lat !== 3) $display("FAIL load_latency got=%0d exp=3", lat); else n_pass++;
        dbg_sel = 3'd1; #1;
        n_total++;
        if (dbg_data !== 8'h7F) $display("FAIL load_r1 got=%h exp=7f", dbg_data); else n_pass++;
        model_regs[1] = 'h7F;
        do_cmd(3'd1, 3'd1, 3'd2, 4'b0010, 3'b000, 3'd0, 1'b0, 8'h00, 1'b1, od, fl, lat, rl);
        dbg_sel = 3'd2; #1;
        n_total++;
        if (dbg_data !== 8'hFE) $display("FAIL add_r2 got=%h exp=fe", dbg_data); else n_pass++;
        n_total++;
        if (fl !== 4'b0110) $display("FAIL add_flags got=%b exp=0110", fl); else n_pass++;
        model_regs[2] = 'hFE;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL out_valid_pulse got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_sub_zero;
        logic [7:0] od;
        logic [3:0] fl;
        int lat, rl;
        do_cmd(3'd1, 3'd1, 3'd5, 4'b0101, 3'b000, 3'd0, 1'b0, 8'h00, 1'b0, od, fl, lat, rl);
        n_total++;
        if (od !== 8'h00) $display("FAIL sub_data got=%h exp=00", od); else n_pass++;
        n_total++;
        if (fl !== 4'b1001) $display("FAIL sub_flags got=%b exp=1001", fl); else n_pass++;
        dbg_sel = 3'd5; #1;
        n_total++;
        if (dbg_data !== 8'h00) $display("FAIL sub_nowrite got=%h exp=00", dbg_data); else n_pass++;
        dbg_sel = 3'd1; #1;
        n_total++;
        if (dbg_data !== 8'h7F) $display("FAIL sub_r1_kept got=%h exp=7f", dbg_data); else n_pass++;
    endtask

    task automatic test_shifts;
        logic [7:0] od;
        logic [3:0] fl;
        int lat, rl;
        do_cmd(3'd0, 3'd0, 3'd1, 4'b0000, 3'b000, 3'd0, 1'b1, 8'h81, 1'b1, od, fl, lat, rl);
        model_regs[1] = 'h81;
        do_cmd(3'd1, 3'd0, 3'd0, 4'b0000, 3'b101, 3'd3, 1'b0, 8'h00, 1'b0, od, fl, lat, rl);
        n_total++;
        if (rl !== 5) $display("FAIL rol_ready_low got=%0d exp=5", rl); else n_pass++;
        n_total++;
        if (lat !== 6) $display("FAIL rol_latency got=%0d exp=6", lat); else n_pass++;
        n_total++;
        if (od !== 8'h0C || fl !== 4'b0000) $display("FAIL rol_result got=%h/%b exp=0c/0000", od, fl); else n_pass++;
        il = 1'b1;
        do_cmd(3'd0, 3'd0, 3'd0, 4'b0000, 3'b010, 3'd1, 1'b1, 8'h81, 1'b0, od, fl, lat, rl);
        il = 1'b0;
        n_total++;
        if (od !== 8'hC0 || fl !== 4'b0101) $display("FAIL shr_result got=%h/%b exp=c0/0101", od, fl); else n_pass++;
        do_cmd(3'd0, 3'd0, 3'd0, 4'b0000, 3'b100, 3'd2, 1'b1, 8'h80, 1'b0, od, fl, lat, rl);
        n_total++;
        if (od !== 8'hE0 || fl !== 4'b0100) $display("FAIL asr_result got=%h/%b exp=e0/0100", od, fl); else n_pass++;
    endtask

    task automatic test_random;
        logic [7:0] od;
        logic [3:0] fl;
        int lat, rl, res, efl, a, k;
        logic [2:0] sa, sb, sd, shf, amt;
        logic [3:0] alu;
        logic ld, wr;
        logic [7:0] din;
        for (int n = 0; n < 40; n++) begin
            sa = 3'($urandom_range(0, 7)); sb = 3'($urandom_range(0, 7)); sd = 3'($urandom_range(0, 7));
            alu = 4'($urandom_range(0, 15)); shf = 3'($urandom_range(0, 7)); amt = 3'($urandom_range(0, 7));
            ld = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 3) != 0);
            din = 8'($urandom_range(0, 255));
            il = 1'($urandom_range(0, 1)); ir = 1'($urandom_range(0, 1));
            a = ld ? int'(din) : model_regs[sa];
            model(a, model_regs[sb], int'(alu), int'(shf), int'(amt), int'(il), int'(ir), res, efl);
            k = steps_of(int'(shf), int'(amt));
            do_cmd(sa, sb, sd, alu, shf, amt, ld, din, wr, od, fl, lat, rl);
            if (wr) model_regs[sd] = res;
            n_total++;
            if (od !== 8'(res) || fl !== 4'(efl))
                $display("FAIL rand%0d_result alu=%h shf=%0d amt=%0d got=%h/%b exp=%h/%b",
                         n, alu, shf, amt, od, fl, 8'(res), 4'(efl));
            else n_pass++;
            n_total++;
            if (lat !== 3 + k) $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, 3 + k); else n_pass++;
            dbg_sel = sd; #1;
            n_total++;
            if (dbg_data !== 8'(model_regs[sd]))
                $display("FAIL rand%0d_bank r%0d got=%h exp=%h", n, sd, dbg_data, 8'(model_regs[sd]));
            else n_pass++;
        end
        il = 1'b0; ir = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n, early;
        @(negedge clk);
        sel_a = 3'd0; sel_b = 3'd0; sel_d = 3'd3; alu_sel = 4'b0000; shift_sel = 3'b000;
        shift_amt = 3'd0; ld_in = 1'b1; in_data = 8'h55; wr_en = 1'b1; op_valid = 1'b1;
        @(posedge clk);
        #1;
        sel_a = 3'd3; sel_b = 3'd3; sel_d = 3'd4; alu_sel = 4'b0010; ld_in = 1'b0; in_data = 8'h00;
        n = 0; early = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n = i;
            if (out_valid) break;
            if (op_ready) early++;
        end
        n_total++;
        if (n !== 3 || early !== 0) $display("FAIL b2b_first lat=%0d early_ready=%0d exp=3/0", n, early); else n_pass++;
        n_total++;
        if (out_data !== 8'h55 || op_ready !== 1'b1)
            $display("FAIL b2b_first_result got=%h rdy=%b exp=55 rdy=1", out_data, op_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (op_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL b2b_accept rdy=%b ov=%b exp=0/0", op_ready, out_valid);
        else n_pass++;
        op_valid = 1'b0;
        n = -1;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
        n_total++;
        if (n !== 3) $display("FAIL b2b_second_latency got=%0d exp=3", n); else n_pass++;
        n_total++;
        if (out_data !== 8'hAA || {z, s, v, c} !== 4'b0110)
            $display("FAIL b2b_second_result got=%h/%b exp=aa/0110", out_data, {z, s, v, c});
        else n_pass++;
        model_regs[3] = 'h55;
        model_regs[4] = 'hAA;
    endtask

    task automatic test_reset_mid;
        logic [7:0] od;
        logic [3:0] fl;
        int lat, rl, pulses, nonzero;
        do_cmd(3'd0, 3'd0, 3'd2, 4'b0000, 3'b000, 3'd0, 1'b1, 8'h81, 1'b1, od, fl, lat, rl);
        @(negedge clk);
        sel_a = 3'd2; sel_b = 3'd0; sel_d = 3'd2; alu_sel = 4'b0000; shift_sel = 3'b101;
        shift_amt = 3'd3; ld_in = 1'b0; wr_en = 1'b1; op_valid = 1'b1;
        @(posedge clk);
        #1 op_valid = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_total++;
        if (pulses !== 0) $display("FAIL midrst_out_valid got=%0d pulses exp=0", pulses); else n_pass++;
        n_total++;
        if (op_ready !== 1'b1) $display("FAIL midrst_op_ready got=%b exp=1", op_ready); else n_pass++;
        nonzero = 0;
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i); #1;
            if (dbg_data !== 8'h00) nonzero++;
            model_regs[i] = 0;
        end
        n_total++;
        if (nonzero !== 0) $display("FAIL midrst_bank got=%0d nonzero regs exp=0", nonzero); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_sub_zero();
        test_shifts();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
